// File: rtl/keccak_squeezer.sv
// Keccak sponge output consumer: captures rate blocks from the core and streams them
// as 32-bit words, issuing squeeze requests until the requested word count is delivered.
module keccak_squeezer #(
  parameter int RATE_WORDS = 34,
  parameter int LEN_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LEN_W-1:0]        num_words,
  input  logic [RATE_WORDS*32-1:0] kc_out,
  input  logic                    kc_out_ready,
  output logic                    kc_squeeze,
  output logic [31:0]             dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int BLK_W = RATE_WORDS * 32;
  localparam int IDX_W = 6;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BLK, STREAM} state_t;

  state_t             state, state_next;
  logic [BLK_W-1:0]   blk;
  logic [IDX_W-1:0]   idx;
  logic [LEN_W-1:0]   remaining;
  logic               capture, fire, last_word, blk_end;

  function automatic logic [31:0] word_at(input logic [BLK_W-1:0] b, input logic [IDX_W-1:0] i);
    return b[32*int'(i) +: 32];
  endfunction

  // kc_out_ready is stale while our own squeeze pulse is in flight, so it is masked then.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    fire       = 1'b0;
    last_word  = (remaining == LEN_W'(1));
    blk_end    = (idx == LAST_IDX);
    case (state)
      IDLE: begin
        if (start && num_words != '0) state_next = WAIT_BLK;
      end
      WAIT_BLK: begin
        if (kc_out_ready && !kc_squeeze) begin
          capture    = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (dout_valid && dout_ready) begin
          fire = 1'b1;
          if (last_word)    state_next = IDLE;
          else if (blk_end) state_next = WAIT_BLK;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      blk        <= '0;
      idx        <= '0;
      remaining  <= '0;
      kc_squeeze <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      kc_squeeze <= 1'b0;
      done       <= 1'b0;
      if (state == IDLE && start) begin
        if (num_words != '0) begin
          remaining <= num_words;
          busy      <= 1'b1;
        end else begin
          done <= 1'b1;
        end
      end
      // Request the following block as soon as this one is captured so it overlaps streaming.
      if (capture) begin
        blk        <= kc_out;
        idx        <= '0;
        dout       <= kc_out[31:0];
        dout_valid <= 1'b1;
        kc_squeeze <= (remaining > LEN_W'(RATE_WORDS));
      end
      if (fire) begin
        remaining <= remaining - 1'b1;
        if (last_word) begin
          dout_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b1;
        end else if (blk_end) begin
          dout_valid <= 1'b0;
        end else begin
          idx  <= idx + 1'b1;
          dout <= word_at(blk, idx + 1'b1);
        end
      end
    end
  end

endmodule

// File: tb/tb_keccak_squeezer.sv
// Randomized bench for keccak_squeezer: a core model serves numbered random blocks and the
// expected word stream is the concatenation of those blocks from the run's starting block.
module tb_keccak_squeezer;

  localparam int RW = 34;
  localparam int NBLK = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [15:0]     num_words = '0;
  logic [RW*32-1:0] kc_out = '0;
  logic            kc_out_ready = 1'b0;
  logic            kc_squeeze;
  logic [31:0]     dout;
  logic            dout_valid;
  logic            dout_ready = 1'b1;
  logic            busy;
  logic            done;

  logic [31:0] blocks [NBLK][RW];
  int cur_blk = 0;
  int wait_cnt = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  keccak_squeezer #(.RATE_WORDS(RW), .LEN_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .kc_out(kc_out), .kc_out_ready(kc_out_ready), .kc_squeeze(kc_squeeze),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Core model: drops ready after a squeeze, presents the next block 23 cycles later.
  initial begin
    for (int b = 0; b < NBLK; b++)
      for (int k = 0; k < RW; k++) blocks[b][k] = $urandom;
    blocks[0][0] = 32'h03020100;
    for (int k = 0; k < RW; k++) kc_out[32*k +: 32] = blocks[0][k];
    kc_out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          for (int k = 0; k < RW; k++) kc_out[32*k +: 32] = blocks[cur_blk][k];
          kc_out_ready = 1'b1;
        end
      end else if (kc_squeeze) begin
        kc_out_ready = 1'b0;
        cur_blk = (cur_blk + 1) % NBLK;
        wait_cnt = 23;
      end
    end
  end

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready.
  task automatic run(input int n, input int mode, input int abort_at,
                     output int first_v, output int last_acc);
    logic [31:0] exp_q[$];
    int b, got, sq, cyc, seen_done, prev_stall, prev_sq;
    logic [31:0] prev_dout;
    b = cur_blk;
    for (int i = 0; i < n; i++) exp_q.push_back(blocks[(b + i / RW) % NBLK][i % RW]);
    got = 0; sq = 0; seen_done = 0; prev_stall = 0; prev_sq = 0; prev_dout = '0;
    first_v = -1; last_acc = 0;
    start = 1'b1;
    num_words = 16'(n);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (seen_done == 0 && cyc < 6000) begin
      if (prev_stall != 0) begin
        chk("hold_valid", 32'(dout_valid), 32'd1);
        chk("hold_data", dout, prev_dout);
      end
      if (kc_squeeze) begin
        sq++;
        chk("squeeze_width", 32'(prev_sq), 32'd0);
        chk("squeeze_after_capture", 32'({dout_valid, got % RW == 0}), 32'd3);
      end
      prev_sq = 32'(kc_squeeze);
      if (done) begin
        seen_done = 1;
        chk("done_word_count", 32'(got), 32'(n));
        chk("done_latency", 32'(cyc), (n == 0) ? 32'd1 : 32'(last_acc + 1));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("valid_at_done", 32'(dout_valid), 32'd0);
      end else begin
        case (mode)
          0: dout_ready = 1'b1;
          1: dout_ready = ((cyc - 1) % 3 == 0);
          default: dout_ready = 1'($urandom_range(0, 1));
        endcase
        if (dout_valid && first_v < 0) first_v = cyc;
        if (dout_valid && dout_ready) begin
          if (got < n) chk("word", dout, exp_q[got]);
          else chk("extra_word", 32'(got), 32'(n - 1));
          got++;
          last_acc = cyc;
          if (abort_at != 0 && got == abort_at) return;
        end
        prev_stall = (dout_valid && !dout_ready) ? 1 : 0;
        prev_dout = dout;
        @(negedge clk);
        cyc++;
      end
    end
    chk("run_finished", 32'(seen_done), 32'd1);
    chk("squeeze_count", 32'(sq), (n == 0) ? 32'd0 : 32'((n + RW - 1) / RW - 1));
    @(negedge clk);
    chk("done_single_pulse", 32'(done), 32'd0);
    chk("idle_valid", 32'(dout_valid), 32'd0);
    chk("idle_squeeze", 32'(kc_squeeze), 32'd0);
    dout_ready = 1'b1;
  endtask

  initial begin
    int fv, la;
    repeat (3) @(negedge clk);
    chk("rst_squeeze", 32'(kc_squeeze), 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run(1, 0, 0, fv, la);
    chk("one_word_latency", 32'(fv), 32'd2);

    run(34, 0, 0, fv, la);
    chk("blk_first_latency", 32'(fv), 32'd2);
    chk("blk_back_to_back", 32'(la - fv), 32'd33);

    run(100, 0, 0, fv, la);
    run(5, 1, 0, fv, la);
    run(0, 0, 0, fv, la);
    chk("zero_no_valid_seen", 32'(fv), 32'hffffffff);

    run(100, 0, 10, fv, la);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_squeeze", 32'(kc_squeeze), 32'd0);
    chk("abort_dout", dout, 32'd0);
    chk("abort_valid", 32'(dout_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_quiet", 32'({kc_squeeze, dout_valid, busy}), 32'd0);
    end
    run(3, 0, 0, fv, la);

    for (int r = 0; r < 6; r++) run($urandom_range(1, 150), 2, 0, fv, la);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/keccak_squeezer.md
Name: keccak_squeezer

Overview:
- Consumer end of the Keccak sponge output interface.
- Captures each 1088-bit rate block presented by the Keccak core and streams it out as 32-bit words over a valid/ready handshake.
- Issues single-cycle squeeze pulses to request further blocks until a requested word count has been delivered.
- Sits between the Keccak core and word-oriented samplers (e.g. polynomial coefficient generation).

Parameters:
- RATE_WORDS, 34, 32-bit words per rate block (1088/32).
- LEN_W, 16, width of the requested word count.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- num_words  in  LEN_W  total words to deliver; sampled with start.
- kc_out  in  1088  rate block from the Keccak core; word k = kc_out[32k+31:32k].
- kc_out_ready  in  1  block valid on kc_out; the core drops it the cycle after a kc_squeeze pulse.
- kc_squeeze  out  1  registered one-cycle request for the next block.
- dout  out  32  output word.
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  downstream accepts dout.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset: state IDLE. kc_squeeze=0, dout=0, dout_valid=0, busy=0, done=0. Block buffer, word index and remaining counter cleared. Reset mid-run aborts immediately; no further words or squeezes are issued.
- State IDLE:
  - start=1 with num_words!=0: latch remaining=num_words, go WAIT_BLK, busy=1 from the next cycle.
  - start=1 with num_words==0: done=1 next cycle, stay IDLE.
- State WAIT_BLK:
  - Block available when kc_out_ready=1 and kc_squeeze=0. The stale out_ready during the squeeze cycle is ignored.
  - On availability: load the 1088-bit buffer from kc_out, idx=0, go STREAM. dout_valid=1 and dout=word 0 in the next cycle (one-cycle capture latency).
  - At capture, if remaining > RATE_WORDS, pulse kc_squeeze for exactly one cycle (the cycle after capture). The next block is then produced while the current one streams.
- State STREAM:
  - dout = buffer word idx. dout and dout_valid are held stable while dout_ready=0.
  - On dout_valid & dout_ready: remaining decrements, idx increments.
  - If remaining reaches 0: dout_valid=0, busy=0, done=1 for one cycle, go IDLE.
  - Else if idx was RATE_WORDS-1: dout_valid=0, go WAIT_BLK.
  - Back-to-back words at one per cycle while dout_ready=1.
- Arithmetic:
  - idx is 6 bits, range 0..RATE_WORDS-1, no wrap.
  - remaining is LEN_W bits and never underflows. The comparison against RATE_WORDS is unsigned.
- start while busy=1 is ignored.
- A new run starts at word 0 of whatever block the core currently presents. Any unconsumed words of a previous run's last block are not carried over.
- Exactly ceil(num_words/RATE_WORDS)-1 squeeze pulses per run. No squeeze is issued after the last needed block.

Test Plan:
- num_words=1, core presents block with word0=0x03020100 -> one word 0x03020100 accepted, no kc_squeeze, done pulse the cycle after the handshake, busy low.
- num_words=34, dout_ready=1 -> words 0..33 on 34 consecutive cycles starting one cycle after kc_out_ready seen, zero squeezes, done once.
- num_words=100, core model raises out_ready 23 cycles after each squeeze with distinct blocks:
  - Required output: 34+34+32 words in order.
  - Exactly 2 kc_squeeze pulses, each one cycle wide and one cycle after capture.
  - The stale out_ready during a pulse is not recaptured.
- Backpressure: num_words=5, dout_ready toggles 1,0,0,1,... -> dout and dout_valid stable through stalls, 5 words in order, remaining reaches 0 with no extra word.
- num_words=0 with start -> done pulse next cycle, dout_valid never asserted, no squeeze.
- Reset asserted mid-run (after word 10 of 100) -> next cycle all outputs 0, state IDLE, no squeeze. A new start with num_words=3 then streams words 0..2 of the currently presented block.
